// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int ADDR_W             = 7;
    localparam int DATA_W             = 32;
    localparam int STARVE_MAX_DEFAULT = 4;

    // IDLE handles single accesses and beat 0 of doubles; DBL2 issues beat 1
    typedef enum logic {
        IDLE = 1'b0,
        DBL2 = 1'b1
    } state_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating up-counter with synchronous clear; tracks how long DMA has been waiting.
module starve_counter #(
    parameter int MAX = 4,
    parameter int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [W-1:0] count;

    // Count up on request, hold at MAX, clear takes priority over increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + W'(1);
        end
    end

    assign at_max = (count == W'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core (single or double-word accesses)
// and a secondary DMA/debug port, with a starvation guard for DMA.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic              core_dbl,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata0,
    input  logic [DATA_W-1:0] core_wdata1,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata0,
    output logic [DATA_W-1:0] core_rdata1,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] Data2Mem,
    input  logic [DATA_W-1:0] ReadDataMem
);

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   rd0_q;
    logic                latch_rd0;
    logic                mem_act;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                starve_inc;
    logic                starve_clr;
    logic                starve_full;
    logic                dma_win;

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (starve_clr),
        .inc    (starve_inc),
        .at_max (starve_full)
    );

    // DMA wins in IDLE when the core is quiet or has starved DMA long enough
    assign dma_win = dma_req && (!core_req || starve_full);

    // Decide the memory access and requester handshakes for this cycle
    always_comb begin
        state_next  = IDLE;
        latch_rd0   = 1'b0;
        mem_act     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        dma_gnt     = 1'b0;
        dma_rdata   = '0;
        core_stall  = 1'b0;
        core_rdata0 = '0;
        core_rdata1 = '0;
        starve_inc  = 1'b0;
        starve_clr  = !dma_req;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (dma_win) begin
                        dma_gnt    = 1'b1;
                        dma_rdata  = ReadDataMem;
                        core_stall = core_req;
                        mem_act    = 1'b1;
                        mem_we     = dma_we;
                        mem_addr   = dma_addr;
                        mem_wdata  = dma_wdata;
                        starve_clr = 1'b1;
                    end else if (core_req) begin
                        mem_act    = 1'b1;
                        mem_we     = core_we;
                        mem_addr   = core_addr;
                        mem_wdata  = core_wdata0;
                        starve_inc = dma_req;
                        if (core_dbl) begin
                            core_stall = 1'b1;
                            latch_rd0  = 1'b1;
                            state_next = DBL2;
                        end else if (!core_we) begin
                            core_rdata0 = ReadDataMem;
                        end
                    end
                end
                DBL2: begin
                    core_rdata0 = rd0_q;
                    core_rdata1 = ReadDataMem;
                    if (core_req) begin
                        mem_act   = 1'b1;
                        mem_we    = core_we;
                        mem_addr  = core_addr + ADDR_W'(1);
                        mem_wdata = core_wdata1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Active-low memory strobes; address and data are zero when idle
    assign CEN      = !mem_act;
    assign WEN      = !(mem_act && mem_we);
    assign OEN      = !(mem_act && !mem_we);
    assign A        = mem_addr;
    assign Data2Mem = mem_wdata;

    // FSM state and the beat-0 read data held for the second beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rd0_q <= '0;
        end else begin
            state <= state_next;
            if (latch_rd0) begin
                rd0_q <= ReadDataMem;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int STARVE = 4;

    logic        clk;
    logic        rst_n;
    logic        core_req;
    logic        core_we;
    logic        core_dbl;
    logic [6:0]  core_addr;
    logic [31:0] core_wdata0;
    logic [31:0] core_wdata1;
    logic        core_stall;
    logic [31:0] core_rdata0;
    logic [31:0] core_rdata1;
    logic        dma_req;
    logic        dma_we;
    logic [6:0]  dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        CEN;
    logic        WEN;
    logic        OEN;
    logic [6:0]  A;
    logic [31:0] Data2Mem;
    logic [31:0] ReadDataMem;

    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];

    int errors = 0;
    int checks = 0;

    bit          m_pending = 1'b0;
    int          m_starve  = 0;
    logic [31:0] m_rd0     = 32'h0;

    logic        obs_cen;
    logic        obs_gnt;
    logic        obs_stall;
    logic [6:0]  obs_a;
    logic [31:0] obs_rd0;
    logic [31:0] obs_rd1;

    dmem_arbiter #(
        .STARVE_MAX (STARVE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_dbl    (core_dbl),
        .core_addr   (core_addr),
        .core_wdata0 (core_wdata0),
        .core_wdata1 (core_wdata1),
        .core_stall  (core_stall),
        .core_rdata0 (core_rdata0),
        .core_rdata1 (core_rdata1),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_gnt     (dma_gnt),
        .dma_rdata   (dma_rdata),
        .CEN         (CEN),
        .WEN         (WEN),
        .OEN         (OEN),
        .A           (A),
        .Data2Mem    (Data2Mem),
        .ReadDataMem (ReadDataMem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read SRAM model
    assign ReadDataMem = (!CEN && !OEN) ? mem[A] : 32'h0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check against the model mid-cycle, commit writes
    task automatic applyStimulus(
        input logic rst, input logic creq, input logic cwe, input logic cdbl,
        input logic [6:0] caddr, input logic [31:0] cw0, input logic [31:0] cw1,
        input logic dreq, input logic dwe, input logic [6:0] daddr, input logic [31:0] dwd);
        logic        e_act, e_we, e_gnt, e_stall;
        logic [6:0]  e_a;
        logic [31:0] e_wd, e_rd0, e_rd1, e_drd, n_rd0;
        bit          n_pending;
        int          n_starve;
        rst_n = rst; core_req = creq; core_we = cwe; core_dbl = cdbl;
        core_addr = caddr; core_wdata0 = cw0; core_wdata1 = cw1;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
        @(negedge clk);
        e_act = 0; e_we = 0; e_gnt = 0; e_stall = 0; e_a = 7'h0;
        e_wd = 0; e_rd0 = 0; e_rd1 = 0; e_drd = 0;
        n_pending = 1'b0; n_starve = dreq ? m_starve : 0; n_rd0 = m_rd0;
        if (!rst) begin
            n_starve = 0; n_rd0 = 32'h0;
        end else if (m_pending) begin
            e_rd0 = m_rd0;
            if (creq) begin
                e_act = 1; e_we = cwe; e_a = caddr + 7'd1; e_wd = cw1;
                e_rd1 = cwe ? 32'h0 : ref_mem[e_a];
            end
        end else if (dreq && (!creq || m_starve >= STARVE)) begin
            e_gnt = 1; e_stall = creq; e_act = 1; e_we = dwe; e_a = daddr; e_wd = dwd;
            e_drd = dwe ? 32'h0 : ref_mem[daddr];
            n_starve = 0;
        end else if (creq) begin
            e_act = 1; e_we = cwe; e_a = caddr; e_wd = cw0;
            if (dreq) n_starve = (m_starve + 1 > STARVE) ? STARVE : m_starve + 1;
            if (cdbl) begin
                e_stall = 1; n_pending = 1'b1;
                n_rd0 = cwe ? 32'h0 : ref_mem[caddr];
            end else begin
                e_rd0 = cwe ? 32'h0 : ref_mem[caddr];
            end
        end
        checkOutput("ctrl{cen,wen,oen,gnt,stall}", {27'h0, CEN, WEN, OEN, dma_gnt, core_stall},
                    {27'h0, !e_act, !(e_act && e_we), !(e_act && !e_we), e_gnt, e_stall});
        checkOutput("addr", {25'h0, A}, {25'h0, e_a});
        if (e_act && e_we) checkOutput("wdata", Data2Mem, e_wd);
        if (rst) begin
            checkOutput("core_rdata0", core_rdata0, e_rd0);
            checkOutput("core_rdata1", core_rdata1, e_rd1);
        end
        if (e_gnt) checkOutput("dma_rdata", dma_rdata, e_drd);
        obs_cen = CEN; obs_gnt = dma_gnt; obs_stall = core_stall;
        obs_a = A; obs_rd0 = core_rdata0; obs_rd1 = core_rdata1;
        if (!CEN && !WEN) mem[A] = Data2Mem;
        if (e_act && e_we) ref_mem[e_a] = e_wd;
        m_pending = n_pending; m_starve = n_starve; m_rd0 = n_rd0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v7f, v0;
        logic        r_creq, r_cwe, r_cdbl, r_rst;
        logic [6:0]  r_caddr;
        logic [31:0] r_w0, r_w1;
        for (int i = 0; i < 128; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5] = 32'hDEADBEEF;     ref_mem[5] = 32'hDEADBEEF;
        mem[7'h21] = 32'h12345678; ref_mem[7'h21] = 32'h12345678;
        v7f = ref_mem[127];
        v0  = ref_mem[0];
        rst_n = 0; core_req = 0; core_we = 0; core_dbl = 0; core_addr = 0;
        core_wdata0 = 0; core_wdata1 = 0; dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with both requesters active: memory idle, no grant, no stall
        applyStimulus(0, 1, 1, 1, 7'h10, 32'h1, 32'h2, 1, 1, 7'h11, 32'h3);
        checkOutput("reset_cen", {31'h0, obs_cen}, 32'h1);
        checkOutput("reset_gnt", {31'h0, obs_gnt}, 32'h0);

        // Single read at 0x05
        applyStimulus(1, 1, 0, 0, 7'h05, 32'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        checkOutput("single_rd_addr", {25'h0, obs_a}, 32'h5);
        checkOutput("single_rd_data", obs_rd0, 32'hDEADBEEF);
        checkOutput("single_rd_stall", {31'h0, obs_stall}, 32'h0);

        // Double write at 0x10
        applyStimulus(1, 1, 1, 1, 7'h10, 32'h1, 32'h2, 0, 0, 7'h0, 32'h0);
        checkOutput("dbl_wr_beat0_addr", {25'h0, obs_a}, 32'h10);
        checkOutput("dbl_wr_beat0_stall", {31'h0, obs_stall}, 32'h1);
        applyStimulus(1, 1, 1, 1, 7'h10, 32'h1, 32'h2, 0, 0, 7'h0, 32'h0);
        checkOutput("dbl_wr_beat1_addr", {25'h0, obs_a}, 32'h11);
        checkOutput("dbl_wr_beat1_stall", {31'h0, obs_stall}, 32'h0);
        checkOutput("dbl_wr_mem10", mem[7'h10], 32'h1);
        checkOutput("dbl_wr_mem11", mem[7'h11], 32'h2);

        // Double read wrapping from 0x7F to 0x00
        applyStimulus(1, 1, 0, 1, 7'h7F, 32'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        applyStimulus(1, 1, 0, 1, 7'h7F, 32'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        checkOutput("wrap_beat1_addr", {25'h0, obs_a}, 32'h0);
        checkOutput("wrap_rdata0", obs_rd0, v7f);
        checkOutput("wrap_rdata1", obs_rd1, v0);

        // Both requesting continuously: four core wins then one DMA grant
        applyStimulus(1, 0, 0, 0, 7'h0, 32'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 0, 0, 7'h30, 32'h0, 32'h0, 1, 0, 7'h40, 32'h0);
            checkOutput($sformatf("starve_gnt_%0d", i), {31'h0, obs_gnt}, {31'h0, (i % 5) == 4});
            checkOutput($sformatf("starve_stall_%0d", i), {31'h0, obs_stall}, {31'h0, (i % 5) == 4});
        end

        // DMA pending across a core double: never granted in the second beat
        applyStimulus(1, 0, 0, 0, 7'h0, 32'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        applyStimulus(1, 1, 0, 1, 7'h50, 32'h0, 32'h0, 1, 1, 7'h60, 32'h77);
        checkOutput("dbl_dma_beat0_gnt", {31'h0, obs_gnt}, 32'h0);
        applyStimulus(1, 1, 0, 1, 7'h50, 32'h0, 32'h0, 1, 1, 7'h60, 32'h77);
        checkOutput("dbl_dma_beat1_gnt", {31'h0, obs_gnt}, 32'h0);
        applyStimulus(1, 0, 0, 0, 7'h0, 32'h0, 32'h0, 1, 1, 7'h60, 32'h77);
        checkOutput("dbl_dma_deferred_gnt", {31'h0, obs_gnt}, 32'h1);

        // Reset during the second beat abandons it
        applyStimulus(1, 0, 0, 0, 7'h0, 32'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        applyStimulus(1, 1, 1, 1, 7'h20, 32'hA0A0A0A0, 32'hB1B1B1B1, 0, 0, 7'h0, 32'h0);
        applyStimulus(0, 1, 1, 1, 7'h20, 32'hA0A0A0A0, 32'hB1B1B1B1, 0, 0, 7'h0, 32'h0);
        checkOutput("rst_dbl2_cen", {31'h0, obs_cen}, 32'h1);
        applyStimulus(1, 0, 0, 0, 7'h0, 32'h0, 32'h0, 0, 0, 7'h0, 32'h0);
        checkOutput("rst_after_cen", {31'h0, obs_cen}, 32'h1);
        checkOutput("rst_beat0_written", mem[7'h20], 32'hA0A0A0A0);
        checkOutput("rst_beat1_not_written", mem[7'h21], 32'h12345678);

        // Randomized traffic; the core mostly holds its request while stalled
        r_creq = 0; r_cwe = 0; r_cdbl = 0; r_caddr = 0; r_w0 = 0; r_w1 = 0;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 49) != 0);
            if (!(obs_stall && $urandom_range(0, 15) != 0)) begin
                r_creq  = ($urandom_range(0, 3) != 0);
                r_cwe   = $urandom_range(0, 1) == 1;
                r_cdbl  = $urandom_range(0, 1) == 1;
                r_caddr = 7'($urandom);
                r_w0    = $urandom;
                r_w1    = $urandom;
            end
            applyStimulus(r_rst, r_creq, r_cwe, r_cdbl, r_caddr, r_w0, r_w1,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          7'($urandom), $urandom);
        end

        for (int i = 0; i < 128; i++) begin
            checkOutput($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
